lcd_bus_sequencer: RTL

//   Sequences the HD44780-style LCD 4-bit bus (RS, E, D4-D7) for the name-badge design.

---
 rtl/lcd_bus_sequencer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/lcd_bus_sequencer.sv
// HD44780-style 4-bit LCD bus sequencer: power-on init, then byte/nibble
// transfers with E strobe timing and post-command execution waits.
module lcd_bus_sequencer #(
    parameter int unsigned E_SETUP     = 1,
    parameter int unsigned E_HIGH      = 8,
    parameter int unsigned NIBBLE_GAP  = 8,
    parameter int unsigned EXEC_CYC    = 64,
    parameter int unsigned LONG_CYC    = 2048,
    parameter int unsigned POWERON_CYC = 20000,
    parameter int unsigned INIT_EN     = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic       req_nibble,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       busy,
    output logic       init_done,
    output logic       RS,
    output logic       E,
    output logic       D4,
    output logic       D5,
    output logic       D6,
    output logic       D7
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned STEP_W = 2;

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(E_SETUP - 1);
    localparam logic [CNT_W-1:0] EHI_LOAD   = CNT_W'(E_HIGH - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(NIBBLE_GAP - 1);
    localparam logic [CNT_W-1:0] EXEC_LOAD  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] PWR_LOAD   = CNT_W'(POWERON_CYC - 1);

    // Init nibbles travel through the same SETUP/EHI/GAP/EXEC phases as
    // requests; init_active_q/init_step_q mark which init transfer is in flight.
    typedef enum logic [2:0] {
        ST_PWR   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_SETUP = 3'd2,
        ST_EHI   = 3'd3,
        ST_GAP   = 3'd4,
        ST_EXEC  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                armed_q, armed_d;
    logic                lat_rs_q, lat_rs_d;
    logic                lat_nib_q, lat_nib_d;
    logic [DATA_W-1:0]   lat_data_q, lat_data_d;
    logic                lo_q, lo_d;
    logic                init_active_q, init_active_d;
    logic [STEP_W-1:0]   init_step_q, init_step_d;
    logic                init_finish_c;
    logic                clear_home_c;
    logic                long_wait_c;

    logic                ready_d, busy_d, init_done_d, rs_d, e_d;
    logic [NIB_W-1:0]    d_q, d_d;

    assign {D7, D6, D5, D4} = d_q;

    // Clear/home commands need the long execution wait
    assign clear_home_c = !lat_nib_q && !lat_rs_q &&
                          (lat_data_q[7:2] == 6'd0) && (lat_data_q[1:0] != 2'd0);
    assign long_wait_c  = init_active_q ? (init_step_q == 2'd0) : clear_home_c;

    // State and datapath registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= (INIT_EN != 0) ? ST_PWR : ST_IDLE;
            cnt_q         <= '0;
            armed_q       <= 1'b0;
            lat_rs_q      <= 1'b0;
            lat_nib_q     <= 1'b0;
            lat_data_q    <= '0;
            lo_q          <= 1'b0;
            init_active_q <= 1'b0;
            init_step_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            armed_q       <= armed_d;
            lat_rs_q      <= lat_rs_d;
            lat_nib_q     <= lat_nib_d;
            lat_data_q    <= lat_data_d;
            lo_q          <= lo_d;
            init_active_q <= init_active_d;
            init_step_q   <= init_step_d;
        end
    end

    // Next state, counter and latched-request logic
    always_comb begin
        state_d       = state_q;
        cnt_d         = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
        armed_d       = armed_q;
        lat_rs_d      = lat_rs_q;
        lat_nib_d     = lat_nib_q;
        lat_data_d    = lat_data_q;
        lo_d          = lo_q;
        init_active_d = init_active_q;
        init_step_d   = init_step_q;
        init_finish_c = 1'b0;

        case (state_q)
            ST_PWR: begin
                if (!armed_q) begin
                    // Counter comes out of reset cleared; load it on the first live cycle
                    armed_d = 1'b1;
                    cnt_d   = PWR_LOAD;
                end else if (cnt_q == '0) begin
                    lat_rs_d      = 1'b0;
                    lat_nib_d     = 1'b1;
                    lat_data_d    = 8'h03;
                    lo_d          = 1'b1;
                    init_active_d = 1'b1;
                    init_step_d   = '0;
                    cnt_d         = SETUP_LOAD;
                    state_d       = ST_SETUP;
                end
            end
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    lat_rs_d   = req_rs;
                    lat_nib_d  = req_nibble;
                    lat_data_d = req_data;
                    lo_d       = req_nibble;
                    cnt_d      = SETUP_LOAD;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = EHI_LOAD;
                    state_d = ST_EHI;
                end
            end
            ST_EHI: begin
                if (cnt_q == '0) begin
                    cnt_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    if (!lo_q) begin
                        lo_d    = 1'b1;
                        cnt_d   = SETUP_LOAD;
                        state_d = ST_SETUP;
                    end else begin
                        cnt_d   = long_wait_c ? LONG_LOAD : EXEC_LOAD;
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    if (init_active_q && (init_step_q != 2'd3)) begin
                        init_step_d = init_step_q + 2'd1;
                        lat_data_d  = (init_step_q == 2'd2) ? 8'h02 : 8'h03;
                        lo_d        = 1'b1;
                        cnt_d       = SETUP_LOAD;
                        state_d     = ST_SETUP;
                    end else begin
                        init_finish_c = init_active_q;
                        init_active_d = 1'b0;
                        state_d       = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state
    always_comb begin
        ready_d     = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        e_d         = (state_d == ST_EHI);
        init_done_d = init_done || init_finish_c || (INIT_EN == 0);
        rs_d        = RS;
        d_d         = d_q;
        if (state_d == ST_SETUP) begin
            rs_d = lat_rs_d;
            d_d  = lo_d ? lat_data_d[3:0] : lat_data_d[7:4];
        end
    end

    // Registered outputs; reset drops E immediately
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            req_ready <= 1'b0;
            busy      <= 1'b0;
            init_done <= 1'b0;
            RS        <= 1'b0;
            E         <= 1'b0;
            d_q       <= '0;
        end else begin
            req_ready <= ready_d;
            busy      <= busy_d;
            init_done <= init_done_d;
            RS        <= rs_d;
            E         <= e_d;
            d_q       <= d_d;
        end
    end

endmodule
